xbar_out_fifo: RTL and testbench

//  Elastic output stage placed directly downstream of each crossbar master port (m0/m1).

---
 rtl/xbar_out_fifo_if.sv | 13 +
 rtl/xbar_out_fifo.sv | 147 ++++++++++++++
 tb/tb_xbar_out_fifo.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xbar_out_fifo_if.sv
// Source-tagged valid/ready word channel used on both sides of the crossbar
// output FIFO. The producer side drives val/src/data; the consumer side drives rdy.
interface xbar_out_fifo_if #(
   parameter int WIDTH = 8
);
   logic             val;
   logic             src;
   logic [WIDTH-1:0] data;
   logic             rdy;

   modport master (output val, output src, output data, input rdy);
   modport slave  (input val, input src, input data, output rdy);
endinterface

// File: rtl/xbar_out_fifo.sv
// Elastic output stage behind one crossbar master port. Buffers up to DEPTH
// {src,data} words, replays them show-ahead on a val/rdy port, and keeps
// per-source accepted-word counters plus an occupancy level for debug readout.
// The head word is held in a register so out_src/out_data come straight from flops.
module xbar_out_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   xbar_out_fifo_if.slave   in_if,
   xbar_out_fifo_if.master  out_if,
   input  logic             cnt_clr,
   output logic [AW:0]      level,
   output logic [CNT_W-1:0] src0_cnt,
   output logic [CNT_W-1:0] src1_cnt
);

   localparam logic [AW:0]      FULL_LVL = DEPTH[AW:0];
   localparam logic [AW:0]      LVL_ZERO = {(AW+1){1'b0}};
   localparam logic [AW:0]      LVL_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0]    PTR_ONE  = AW'(1'b1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   // storage entries are {src, data}; contents are not reset
   logic [WIDTH:0]     mem_q [DEPTH];

   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [AW:0]        level_q, level_d;
   logic               in_rdy_q, in_rdy_d;
   logic               out_val_q, out_val_d;
   logic [WIDTH:0]     head_q, head_d;
   logic [CNT_W-1:0]   src0_cnt_q, src0_cnt_d;
   logic [CNT_W-1:0]   src1_cnt_q, src1_cnt_d;
   logic               push;
   logic               pop;

   // handshakes, pointer/level bookkeeping and next head word
   always_comb begin
      push      = in_if.val & in_rdy_q;
      pop       = out_val_q & out_if.rdy;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      head_d    = {(WIDTH+1){1'b0}};

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push, pop})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase

      in_rdy_d  = (level_d != FULL_LVL);
      out_val_d = (level_d != LVL_ZERO);

      // the next head is either the word being written right now (it lands in
      // the slot the read pointer will point at) or an already-stored entry
      if (level_d == LVL_ZERO) begin
         head_d = {(WIDTH+1){1'b0}};
      end else if (push && (rd_ptr_d == wr_ptr_q)) begin
         head_d = {in_if.src, in_if.data};
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   // saturating per-source counters; a clear wins over a coincident push
   always_comb begin
      src0_cnt_d = src0_cnt_q;
      src1_cnt_d = src1_cnt_q;
      if (cnt_clr) begin
         src0_cnt_d = CNT_ZERO;
         src1_cnt_d = CNT_ZERO;
      end else if (push && !in_if.src) begin
         if (src0_cnt_q != CNT_MAX) begin
            src0_cnt_d = src0_cnt_q + CNT_ONE;
         end else begin
            src0_cnt_d = src0_cnt_q;
         end
      end else if (push && in_if.src) begin
         if (src1_cnt_q != CNT_MAX) begin
            src1_cnt_d = src1_cnt_q + CNT_ONE;
         end else begin
            src1_cnt_d = src1_cnt_q;
         end
      end else begin
         src0_cnt_d = src0_cnt_q;
         src1_cnt_d = src1_cnt_q;
      end
   end

   // control and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= {AW{1'b0}};
         rd_ptr_q   <= {AW{1'b0}};
         level_q    <= LVL_ZERO;
         in_rdy_q   <= 1'b0;
         out_val_q  <= 1'b0;
         head_q     <= {(WIDTH+1){1'b0}};
         src0_cnt_q <= CNT_ZERO;
         src1_cnt_q <= CNT_ZERO;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         in_rdy_q   <= in_rdy_d;
         out_val_q  <= out_val_d;
         head_q     <= head_d;
         src0_cnt_q <= src0_cnt_d;
         src1_cnt_q <= src1_cnt_d;
      end
   end

   // storage write on an accepted word
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {in_if.src, in_if.data};
      end
   end

   assign in_if.rdy   = in_rdy_q;
   assign out_if.val  = out_val_q;
   assign out_if.src  = head_q[WIDTH];
   assign out_if.data = head_q[WIDTH-1:0];
   assign level       = level_q;
   assign src0_cnt    = src0_cnt_q;
   assign src1_cnt    = src1_cnt_q;

endmodule

// File: tb/tb_xbar_out_fifo.sv
// Self-checking bench for xbar_out_fifo: directed scenarios plus randomized
// traffic, compared against a queue-based reference model.
module tb_xbar_out_fifo;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cnt_clr = 1'b0;

   always #5 clk = ~clk;

   xbar_out_fifo_if #(.WIDTH(WIDTH)) in_if ();
   xbar_out_fifo_if #(.WIDTH(WIDTH)) out_if ();
   xbar_out_fifo_if #(.WIDTH(WIDTH)) in2_if ();
   xbar_out_fifo_if #(.WIDTH(WIDTH)) out2_if ();

   logic [2:0]  level, level2;
   logic [15:0] src0_cnt, src1_cnt;
   logic [1:0]  s0_small, s1_small;

   xbar_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_if(in_if), .out_if(out_if),
      .cnt_clr(cnt_clr), .level(level), .src0_cnt(src0_cnt), .src1_cnt(src1_cnt)
   );

   // second instance with narrow counters sees identical traffic
   assign in2_if.val  = in_if.val;
   assign in2_if.src  = in_if.src;
   assign in2_if.data = in_if.data;
   assign out2_if.rdy = out_if.rdy;

   xbar_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_if(in2_if), .out_if(out2_if),
      .cnt_clr(cnt_clr), .level(level2), .src0_cnt(s0_small), .src1_cnt(s1_small)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: FIFO contents, registered ready flag, unbounded counts
   logic [8:0] q[$];
   bit         m_rdy;
   int         m_c0, m_c1;

   wire [45:0] obs = {in_if.rdy, out_if.val, out_if.src, out_if.data, level, src0_cnt, src1_cnt};

   task automatic model_reset();
      q.delete();
      m_rdy = 1'b0;
      m_c0  = 0;
      m_c1  = 0;
   endtask

   function automatic logic [45:0] exp_vec();
      logic [8:0] head;
      int c0, c1;
      head = (q.size() != 0) ? q[0] : 9'h000;
      c0 = (m_c0 > 65535) ? 65535 : m_c0;
      c1 = (m_c1 > 65535) ? 65535 : m_c1;
      return {m_rdy, (q.size() != 0), head, 3'(q.size()), 16'(c0), 16'(c1)};
   endfunction

   function automatic logic [3:0] exp_small();
      int c0, c1;
      c0 = (m_c0 > 3) ? 3 : m_c0;
      c1 = (m_c1 > 3) ? 3 : m_c1;
      return {2'(c0), 2'(c1)};
   endfunction

   // one clock: model follows the rules on the inputs present at the edge
   task automatic cycle();
      bit push, pop;
      logic [8:0] word;
      push = in_if.val && m_rdy;
      pop  = (q.size() != 0) && out_if.rdy;
      word = {in_if.src, in_if.data};
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (push) q.push_back(word);
      if (cnt_clr) begin
         m_c0 = 0;
         m_c1 = 0;
      end else if (push) begin
         if (word[8]) m_c1++;
         else m_c0++;
      end
      m_rdy = (q.size() != DEPTH);
      #1;
   endtask

   task automatic drive(input bit val, input bit src, input logic [7:0] data, input bit ordy);
      in_if.val   = val;
      in_if.src   = src;
      in_if.data  = data;
      out_if.rdy  = ordy;
   endtask

   task automatic test_reset();
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      rst_n = 1'b0;
      model_reset();
      #12;
      n_checks++;
      if (obs !== 46'h0) begin
         n_fail++;
         $display("FAIL reset_state: got %h expected %h", obs, 46'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      n_checks++;
      if (in_if.rdy !== 1'b1 || out_if.val !== 1'b0 || level !== 3'd0) begin
         n_fail++;
         $display("FAIL first_edge: got rdy=%b val=%b level=%0d expected rdy=1 val=0 level=0",
                  in_if.rdy, out_if.val, level);
      end
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_checks++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL idle: got %h expected %h", obs, exp_vec());
         end
      end
   endtask

   task automatic test_order();
      logic [8:0] words [3];
      words[0] = 9'h011;
      words[1] = 9'h122;
      words[2] = 9'h033;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, words[i][8], words[i][7:0], 1'b0);
         cycle();
      end
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_checks++;
         if ({out_if.val, out_if.src, out_if.data, level, src0_cnt, src1_cnt} !==
             {1'b1, 9'h011, 3'd3, 16'd2, 16'd1}) begin
            n_fail++;
            $display("FAIL order_hold: got val=%b data=%h level=%0d c0=%0d c1=%0d expected 1 011 3 2 1",
                     out_if.val, {out_if.src, out_if.data}, level, src0_cnt, src1_cnt);
         end
      end
      out_if.rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({out_if.val, out_if.src, out_if.data} !== {1'b1, words[i]}) begin
            n_fail++;
            $display("FAIL order_drain: got %b/%h expected 1/%h", out_if.val,
                     {out_if.src, out_if.data}, words[i]);
         end
         cycle();
      end
      n_checks++;
      if (obs !== exp_vec() || out_if.val !== 1'b0) begin
         n_fail++;
         $display("FAIL order_empty: got %h expected %h", obs, exp_vec());
      end
   endtask

   task automatic test_full();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 1'($urandom_range(1)), 8'($urandom_range(255)), 1'b0);
         cycle();
      end
      n_checks++;
      if (in_if.rdy !== 1'b0 || level !== 3'd4 || obs !== exp_vec()) begin
         n_fail++;
         $display("FAIL full: got rdy=%b level=%0d vec=%h expected rdy=0 level=4 vec=%h",
                  in_if.rdy, level, obs, exp_vec());
      end
      drive(1'b1, 1'b1, 8'hA5, 1'b0);
      cycle();
      n_checks++;
      if (level !== 3'd4 || obs !== exp_vec()) begin
         n_fail++;
         $display("FAIL full_ignore: got level=%0d vec=%h expected level=4 vec=%h",
                  level, obs, exp_vec());
      end
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      cycle();
      n_checks++;
      if (in_if.rdy !== 1'b1 || level !== 3'd3) begin
         n_fail++;
         $display("FAIL full_pop: got rdy=%b level=%0d expected rdy=1 level=3", in_if.rdy, level);
      end
      drive(1'b1, 1'b1, 8'h5C, 1'b0);
      cycle();
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < DEPTH + 1; i++) begin
         n_checks++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL wrap_drain: got %h expected %h", obs, exp_vec());
         end
         cycle();
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b0, 8'(i), 1'b1);
         cycle();
         n_checks++;
         if ({out_if.val, level, out_if.data} !== {1'b1, 3'd1, 8'(i)}) begin
            n_fail++;
            $display("FAIL back_to_back: got val=%b level=%0d data=%h expected 1 1 %h",
                     out_if.val, level, out_if.data, 8'(i));
         end
      end
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      cycle();
      n_checks++;
      if (obs !== exp_vec()) begin
         n_fail++;
         $display("FAIL b2b_drain: got %h expected %h", obs, exp_vec());
      end
   endtask

   task automatic test_saturate();
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      cnt_clr = 1'b1;
      cycle();
      cnt_clr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, 8'($urandom_range(255)), 1'b1);
         cycle();
      end
      n_checks++;
      if (s1_small !== 2'd3 || src1_cnt !== 16'd5 || {s0_small, s1_small} !== exp_small()) begin
         n_fail++;
         $display("FAIL saturate: got small=%0d wide=%0d expected small=3 wide=5", s1_small, src1_cnt);
      end
      drive(1'b1, 1'b0, 8'h77, 1'b1);
      cnt_clr = 1'b1;
      cycle();
      cnt_clr = 1'b0;
      n_checks++;
      if ({s0_small, s1_small, src0_cnt, src1_cnt} !== 36'h0) begin
         n_fail++;
         $display("FAIL clr_override: got %0d %0d %0d %0d expected all 0",
                  s0_small, s1_small, src0_cnt, src1_cnt);
      end
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      cycle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(3) != 0), 1'($urandom_range(1)), 8'($urandom_range(255)),
               1'($urandom_range(2) != 0));
         cnt_clr = 1'($urandom_range(31) == 0);
         cycle();
         n_checks++;
         if (obs !== exp_vec() || {s0_small, s1_small} !== exp_small()) begin
            n_fail++;
            $display("FAIL random[%0d]: got %h/%h expected %h/%h", i, obs,
                     {s0_small, s1_small}, exp_vec(), exp_small());
         end
      end
      cnt_clr = 1'b0;
   endtask

   task automatic test_reset_mid();
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < DEPTH + 1; i++) cycle();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 8'hE0 + 8'(i), 1'b0);
         cycle();
      end
      n_checks++;
      if (level !== 3'd3) begin
         n_fail++;
         $display("FAIL pre_reset_level: got %0d expected 3", level);
      end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if ({out_if.val, level, in_if.rdy, out_if.src, out_if.data} !== 13'h0) begin
         n_fail++;
         $display("FAIL async_reset: got val=%b level=%0d rdy=%b data=%h expected all 0",
                  out_if.val, level, in_if.rdy, out_if.data);
      end
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_checks++;
         if (obs !== exp_vec() || out_if.val !== 1'b0 || out_if.data !== 8'h00) begin
            n_fail++;
            $display("FAIL stale_after_reset: got %h expected %h", obs, exp_vec());
         end
      end
      drive(1'b1, 1'b0, 8'h3C, 1'b0);
      cycle();
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      n_checks++;
      if ({out_if.val, out_if.src, out_if.data} !== 10'h23C || obs !== exp_vec()) begin
         n_fail++;
         $display("FAIL fresh_after_reset: got %h expected %h", obs, exp_vec());
      end
   endtask

   initial begin
      test_reset();
      test_order();
      test_full();
      test_back_to_back();
      test_saturate();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
